flash_fetch_initiator: RTL and testbench

- AXI4-Lite read initiator: the requester that drives the flash controller's memory read port.
- Takes a (start address, word count) request from the cache/boot loader and issues sequential 32-bit AXI4-Lite reads, with up to MAX_OUTSTANDING reads in flight.
- Buffers returned words in an internal FIFO and presents them as a valid/ready stream with a last flag.

---
 rtl/flash_fetch_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 90 +++++++++
 rtl/flash_fetch_initiator.sv | 190 +++++++++++++++++++
 tb/tb_flash_fetch_initiator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_fetch_pkg.sv
// -----------------------------------------------------------------------------
// flash_fetch_pkg
// Shared types and constants for the flash fetch initiator.
//   fetch_state_t  : top-level control states (idle, issuing reads, draining)
//   AXI_OKAY       : AXI response code for a good read beat
//   WORD_BYTES     : bytes per fetched word (address step)
//   LEN_W / CNT_W  : request length field width / internal word-count width
//   len_to_count() : maps the 8-bit request length to a word count (0 -> 256)
// -----------------------------------------------------------------------------
package flash_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ISSUE = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam int         WORD_BYTES = 4;
  localparam int         LEN_W      = 8;
  localparam int         CNT_W      = 9;

  // A zero length field encodes the maximum transfer of 256 words.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      return CNT_W'(256);
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous show-ahead FIFO with a registered head output.
//   CLK, RST  : clock, synchronous active-high reset
//   wr_en     : push request (accepted when not full, or when full and popping)
//   wr_data   : word to push
//   rd_en     : consumer ready; pops the head when rd_valid is high
//   rd_data   : registered head entry
//   rd_valid  : registered head-valid flag
//   count     : number of stored entries (head included)
//   full      : count == DEPTH
//   empty     : count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 33,
  parameter int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic [COUNT_W-1:0] remain;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == COUNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is only allowed when the head leaves the same cycle.
  // remain is the number of entries still stored once this cycle's pop is taken.
  always_comb begin
    pop        = rd_en && rd_valid;
    push       = wr_en && (!full || pop);
    rd_ptr_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
    remain     = count - COUNT_W'(pop);
    count_nxt  = remain + COUNT_W'(push);
  end

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head. When nothing else is stored
  // the incoming word bypasses the array straight into the head register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      if (remain != '0) begin
        rd_data <= mem[rd_ptr_nxt];
      end else if (push) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/flash_fetch_initiator.sv
// -----------------------------------------------------------------------------
// flash_fetch_initiator
// AXI4-Lite read initiator for the flash controller. Accepts a (start address,
// word count) request, issues sequential word reads with a bounded number in
// flight, buffers the returned data and streams it out with a last flag.
//
// Optional build macro: FLASH_FETCH_RRESP_CHECK_EN adds m_axi_rresp and a
// sticky fetch_err flag (cleared when the next request is accepted).
//
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only when idle)
//   req_addr, req_len    : start byte address (low 2 bits ignored), length (0=256)
//   m_axi_ar*            : AXI4-Lite read address channel
//   m_axi_r*             : AXI4-Lite read data channel
//   out_valid/out_ready  : output word stream handshake
//   out_data, out_last   : stream word and end-of-request marker
//   busy                 : high whenever a request is in progress
//   fetch_err            : (optional) sticky bad-response flag
// -----------------------------------------------------------------------------
module flash_fetch_initiator
  import flash_fetch_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         FIFO_DEPTH      = 8,
  parameter logic [2:0] ARPROT_VAL      = 3'b100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
`ifdef FLASH_FETCH_RRESP_CHECK_EN
  input  logic [1:0]  m_axi_rresp,
  output logic        fetch_err,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int FCOUNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [31:0]         araddr_q;
  logic [CNT_W-1:0]    issue_left;
  logic [CNT_W-1:0]    recv_left;
  logic [3:0]          outstanding;
  logic                ar_hold;
  logic                credit_ok;
  logic                ar_hs;
  logic                r_hs;
  logic                req_hs;
  logic [FCOUNT_W-1:0] fifo_count;
  logic                fifo_empty;
  logic                fifo_full_unused;
  logic [1:0]          addr_lsb_unused;
  logic [32:0]         fifo_rd;

  assign addr_lsb_unused = req_addr[1:0];
  assign m_axi_arprot    = ARPROT_VAL;
  assign m_axi_araddr    = araddr_q;

  // Every issued read reserves a FIFO slot until its word is popped, so the
  // R channel never needs to be throttled.
  assign credit_ok = ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH) &&
                     (int'(outstanding) < MAX_OUTSTANDING);

  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign req_hs = req_valid && req_ready;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control outputs. Once arvalid is raised, ar_hold keeps it
  // up regardless of credit until the address is taken.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    busy          = 1'b1;
    m_axi_rready  = 1'b1;
    m_axi_arvalid = 1'b0;
    unique case (state)
      FETCH_IDLE: begin
        req_ready    = 1'b1;
        busy         = 1'b0;
        m_axi_rready = 1'b0;
        if (req_valid) begin
          state_nxt = FETCH_ISSUE;
        end
      end
      FETCH_ISSUE: begin
        m_axi_arvalid = ar_hold || credit_ok;
        if (m_axi_arvalid && m_axi_arready && (issue_left == CNT_W'(1))) begin
          state_nxt = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if ((recv_left == '0) && fifo_empty) begin
          state_nxt = FETCH_IDLE;
        end
      end
      default: begin
        state_nxt = FETCH_IDLE;
      end
    endcase
  end

  // Address, word counters and the in-flight read count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      araddr_q    <= '0;
      issue_left  <= '0;
      recv_left   <= '0;
      outstanding <= '0;
      ar_hold     <= 1'b0;
    end else begin
      ar_hold <= m_axi_arvalid && !m_axi_arready;
      if (req_hs) begin
        araddr_q   <= {req_addr[31:2], 2'b00};
        issue_left <= len_to_count(req_len);
        recv_left  <= len_to_count(req_len);
      end else if (ar_hs) begin
        araddr_q   <= araddr_q + 32'(WORD_BYTES);
        issue_left <= issue_left - CNT_W'(1);
      end
      if (r_hs) begin
        recv_left <= recv_left - CNT_W'(1);
      end
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef FLASH_FETCH_RRESP_CHECK_EN
  // Sticky error flag for any non-OKAY read beat in the current request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_err <= 1'b0;
    end else if (req_hs) begin
      fetch_err <= 1'b0;
    end else if (r_hs && (m_axi_rresp != AXI_OKAY)) begin
      fetch_err <= 1'b1;
    end
  end
`endif

  // The beat that brings recv_left to zero is the last word of the request.
  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (33),
    .COUNT_W(FCOUNT_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (r_hs),
    .wr_data ({(recv_left == CNT_W'(1)), m_axi_rdata}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .rd_valid(out_valid),
    .count   (fifo_count),
    .full    (fifo_full_unused),
    .empty   (fifo_empty)
  );

  assign out_data = fifo_rd[31:0];
  assign out_last = fifo_rd[32];

endmodule

// File: tb/tb_flash_fetch_initiator.sv
// -----------------------------------------------------------------------------
// tb_flash_fetch_initiator
// Self-checking bench: an AXI read slave and stream consumer with randomised
// timing, plus a request-level model (expected address i = start + 4*i, data =
// address ^ A5A5A5A5, last on word n-1, bounded reads in flight / buffered).
// -----------------------------------------------------------------------------
module tb_flash_fetch_initiator;

  localparam int MAX_OUT = 4;
  localparam int DEPTH   = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef FLASH_FETCH_RRESP_CHECK_EN
  logic        fetch_err;
`endif

  flash_fetch_initiator #(
    .MAX_OUTSTANDING(MAX_OUT),
    .FIFO_DEPTH     (DEPTH),
    .ARPROT_VAL     (3'b100)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_rdata  (m_axi_rdata),
`ifdef FLASH_FETCH_RRESP_CHECK_EN
    .m_axi_rresp  (m_axi_rresp),
    .fetch_err    (fetch_err),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model state for the current request.
  bit          active = 1'b0;
  logic [31:0] startAddr = '0;
  int          reqLen = 0;
  int          arCount = 0;
  int          rCount = 0;
  int          popCount = 0;
  logic [31:0] rQueue[$];
  bit          prevArPending = 1'b0;
  logic [31:0] prevAraddr = '0;
  bit          errExp = 1'b0;

  // Slave / consumer timing knobs.
  int pArready = 100;
  int pRvalid = 100;
  int pOutReady = 100;
  int arDelay = 0;
  int arWaitCnt = 0;
  int errBeat = -1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] expAddr(input int i);
    return startAddr + 32'(i * 4);
  endfunction

  // Slave and consumer: drive inputs on the falling edge, then sample what the
  // DUT will see at the next rising edge and advance the model.
  always @(negedge CLK) begin
    if (RST) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
    end else begin
      m_axi_arready = (arWaitCnt >= arDelay) && ($urandom_range(99) < pArready);
      m_axi_rvalid  = (rQueue.size() > 0) && ($urandom_range(99) < pRvalid);
    end
    m_axi_rdata = (rQueue.size() > 0) ? memWord(rQueue[0]) : $urandom;
    m_axi_rresp = (rCount == errBeat) ? 2'b10 : 2'b00;
    out_ready   = ($urandom_range(99) < pOutReady);
    #1;
    if (RST) begin
      active        = 1'b0;
      rQueue.delete();
      prevArPending = 1'b0;
      arWaitCnt     = 0;
      errExp        = 1'b0;
    end else begin
      if (prevArPending) begin
        checkOutput("ar_hold_valid", m_axi_arvalid, 1);
        checkOutput("ar_hold_addr", m_axi_araddr, prevAraddr);
      end
`ifdef FLASH_FETCH_RRESP_CHECK_EN
      checkOutput("fetch_err", fetch_err, errExp);
`endif
      if (req_valid && req_ready) begin
        active    = 1'b1;
        startAddr = {req_addr[31:2], 2'b00};
        reqLen    = (req_len == 0) ? 256 : int'(req_len);
        arCount   = 0;
        rCount    = 0;
        popCount  = 0;
        errExp    = 1'b0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        checkOutput("ar_in_range", (arCount < reqLen) && active, 1);
        checkOutput("araddr", m_axi_araddr, expAddr(arCount));
        checkOutput("arprot", m_axi_arprot, 3'b100);
        rQueue.push_back(m_axi_araddr);
        arCount++;
        arWaitCnt = 0;
      end else if (m_axi_arvalid) begin
        arWaitCnt++;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        void'(rQueue.pop_front());
        if (m_axi_rresp != 2'b00) errExp = 1'b1;
        rCount++;
      end
      if (out_valid && out_ready) begin
        checkOutput("out_in_range", (popCount < reqLen) && active, 1);
        checkOutput("out_data", out_data, memWord(expAddr(popCount)));
        checkOutput("out_last", out_last, popCount == reqLen - 1);
        popCount++;
      end
      if (active) begin
        checkOutput("inflight_limit", (arCount - rCount) <= MAX_OUT, 1);
        checkOutput("buffer_limit", (arCount - popCount) <= DEPTH, 1);
      end
      prevArPending = m_axi_arvalid && !m_axi_arready;
      prevAraddr    = m_axi_araddr;
    end
  end

  task automatic checkResetState();
    checkOutput("rst_arvalid", m_axi_arvalid, 0);
    checkOutput("rst_rready", m_axi_rready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_araddr", m_axi_araddr, 0);
  endtask

  // Present one request and hold it until it is accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len);
    int waited = 0;
    @(negedge CLK);
    while (!req_ready && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge CLK);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_len   = 8'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge CLK);
      #2;
      done = (popCount == reqLen) && !busy;
      n++;
    end
    checkOutput("done_in_time", done, 1);
    checkOutput("done_ar_count", arCount, reqLen);
    checkOutput("done_pop_count", popCount, reqLen);
    checkOutput("done_req_ready", req_ready, 1);
    checkOutput("done_out_valid", out_valid, 0);
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    out_ready     = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    checkResetState();
    RST = 1'b0;

    $display("[TB] basic fetch");
    applyStimulus(32'h0000_1003, 8'd4);
    waitDone(200);

    $display("[TB] output backpressure");
    pOutReady = 0;
    applyStimulus(32'h0000_2000, 8'd16);
    repeat (40) @(negedge CLK);
    #2;
    checkOutput("bp_ar_count", arCount, DEPTH);
    checkOutput("bp_arvalid", m_axi_arvalid, 0);
    pOutReady = 100;
    waitDone(300);

    $display("[TB] outstanding limit");
    pRvalid = 0;
    applyStimulus(32'h0000_3000, 8'd8);
    repeat (20) @(negedge CLK);
    #2;
    checkOutput("os_ar_count", arCount, MAX_OUT);
    checkOutput("os_arvalid", m_axi_arvalid, 0);
    pRvalid = 100;
    waitDone(300);

    $display("[TB] stalled address and wrap");
    arDelay = 5;
    applyStimulus(32'hFFFF_FFF8, 8'd3);
    waitDone(300);
    checkOutput("wrap_ar_count", arCount, 3);
    arDelay = 0;

    $display("[TB] length 256");
    pArready = 60; pRvalid = 60; pOutReady = 60;
    applyStimulus(32'h0000_4000, 8'd0);
    waitDone(20000);
    checkOutput("len0_words", popCount, 256);

    $display("[TB] reset mid-transfer");
    applyStimulus(32'h0000_5000, 8'd0);
    for (int i = 0; i < 5000 && popCount < 10; i++) @(negedge CLK);
    checkOutput("mid_progress", popCount >= 10, 1);
    RST = 1'b1;
    @(negedge CLK);
    #2;
    checkResetState();
    RST = 1'b0;
    applyStimulus(32'h0000_6000, 8'd2);
    waitDone(300);

    $display("[TB] random requests");
    for (int k = 0; k < 6; k++) begin
      pArready  = $urandom_range(100, 30);
      pRvalid   = $urandom_range(100, 30);
      pOutReady = $urandom_range(100, 30);
      applyStimulus($urandom, 8'($urandom_range(40, 1)));
      waitDone(3000);
    end
    pArready = 100; pRvalid = 100; pOutReady = 100;

`ifdef FLASH_FETCH_RRESP_CHECK_EN
    $display("[TB] response error flag");
    errBeat = 1;
    applyStimulus(32'h0000_7000, 8'd3);
    waitDone(300);
    checkOutput("err_sticky", fetch_err, 1);
    errBeat = -1;
    applyStimulus(32'h0000_8000, 8'd1);
    #2;
    checkOutput("err_cleared", fetch_err, 0);
    waitDone(300);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
